fas_peak_analyzer: RTL

//  Parametrised successor to the FAS analysis stage. Takes N complex FFT bins

---
 rtl/fas_pkg.sv | 32 +++
 rtl/fas_argmax_tree.sv | 41 ++++
 rtl/fas_peak_analyzer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// fas_pkg
//   Shared definitions for the FAS peak analysis stage.
//   - clog2(): constant-evaluable ceiling log2, used to size indices.
//   - mag_width(): width of an unsigned |X|^2 value for a DW-bit component.
//   - `FAS_PACK_BIN(re, im): packs one complex bin as {re, im}. This is the
//     lane layout the FFT produces and the analyzer consumes.
//
//   Tie-break rule: when two bins have equal magnitude, the lower bin index
//   wins. Inside a beat the comparison tree keeps the lower lane on equality.
//   Across beats a later beat only replaces the running max when it is
//   strictly greater. Together these match the golden comparison tree.
`ifndef FAS_PKG_SV
`define FAS_PKG_SV

`define FAS_PACK_BIN(re, im) {(re), (im)}

package fas_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int mag_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

`endif

// File: rtl/fas_argmax_tree.sv
// fas_argmax_tree
//   Combinational reduction of LANES unsigned magnitudes to the position and
//   value of the largest one. The reduction has log2(LANES) levels. When two
//   magnitudes are equal, the lower lane index wins.
// Ports
//   mags  in   LANES*MAGW   lane L at [L*MAGW +: MAGW]
//   idx   out  IW           winning lane
//   mag   out  MAGW         winning magnitude
module fas_argmax_tree #(
  parameter int LANES = 16,
  parameter int MAGW  = 32,
  parameter int IW    = 4
) (
  input  logic [LANES*MAGW-1:0] mags,
  output logic [IW-1:0]         idx,
  output logic [MAGW-1:0]       mag
);

  logic [MAGW-1:0] node_mag [LANES];
  logic [IW-1:0]   node_idx [LANES];

  // Node i of each level overwrites itself with its right partner only when
  // the partner is strictly larger, so equality keeps the lower lane.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node_mag[i] = mags[i*MAGW +: MAGW];
      node_idx[i] = IW'(i);
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int i = 0; i + step < LANES; i = i + 2 * step) begin
        if (node_mag[i + step] > node_mag[i]) begin
          node_mag[i] = node_mag[i + step];
          node_idx[i] = node_idx[i + step];
        end
      end
    end
    idx = node_idx[0];
    mag = node_mag[0];
  end

endmodule

// File: rtl/fas_peak_analyzer.sv
// fas_peak_analyzer
//   Computes |X[k]|^2 for N complex FFT bins, which arrive LANES bins per beat.
//   Reports the peak bin, its magnitude, and whether that magnitude reaches a
//   threshold. The pipeline has three stages:
//     S1  per-lane power
//     S2  in-beat argmax
//     S3  frame running max plus the output register
//   All stages advance together. They freeze while a result is waiting for
//   out_ready.
// Ports
//   clk, rst       clock and synchronous active-high reset
//   in_valid/ready input beat handshake
//   in_data        LANES packed bins {re, im}; bin = beat*LANES + lane
//   thresh         magnitude threshold, taken with the frame's last beat
//   out_valid/ready result handshake; the result is held until consumed
//   freq           peak bin index
//   peak_mag       peak |X|^2 (unsigned)
//   hit            peak_mag >= thresh
module fas_peak_analyzer
  import fas_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 16,
  parameter int DW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*2*DW-1:0] in_data,
  input  logic [2*DW-1:0]       thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clog2(N)-1:0]   freq,
  output logic [2*DW-1:0]       peak_mag,
  output logic                  hit
);

  localparam int MAGW      = mag_width(DW);
  localparam int BEATS     = N / LANES;
  localparam int LOG_LANES = clog2(LANES);
  localparam int IW        = (LANES > 1) ? LOG_LANES : 1;
  localparam int BW        = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int FW        = clog2(N);

  logic en;
  logic accept;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !rst;
  assign accept   = in_valid && in_ready;

  // The squares of two sign-extended components are each at most
  // 2^(2DW-2). Their sum therefore fits the unsigned MAGW-bit result.
  function automatic logic [MAGW-1:0] bin_power(input logic [MAGW-1:0] bin);
    logic signed [MAGW-1:0] re;
    logic signed [MAGW-1:0] im;
    re = MAGW'(signed'(bin[MAGW-1:DW]));
    im = MAGW'(signed'(bin[DW-1:0]));
    return $unsigned(re * re) + $unsigned(im * im);
  endfunction

  logic [LANES*MAGW-1:0] lane_mags;

  always_comb begin
    lane_mags = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_mags[l*MAGW +: MAGW] = bin_power(in_data[l*MAGW +: MAGW]);
    end
  end

  // Beat counter: holds across in_valid gaps and wraps on the last beat.
  logic [BW-1:0] beat_cnt;
  logic          beat_last;

  assign beat_last = (beat_cnt == BW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

  // S1
  logic                  s1_valid;
  logic                  s1_last;
  logic [BW-1:0]         s1_beat;
  logic [LANES*MAGW-1:0] s1_mags;
  logic [MAGW-1:0]       s1_thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_beat   <= '0;
      s1_mags   <= '0;
      s1_thresh <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last   <= beat_last;
        s1_beat   <= beat_cnt;
        s1_mags   <= lane_mags;
        s1_thresh <= thresh;
      end
    end
  end

  // S2
  logic [IW-1:0]   tree_idx;
  logic [MAGW-1:0] tree_mag;

  fas_argmax_tree #(
    .LANES(LANES),
    .MAGW (MAGW),
    .IW   (IW)
  ) u_tree (
    .mags(s1_mags),
    .idx (tree_idx),
    .mag (tree_mag)
  );

  logic            s2_valid;
  logic            s2_first;
  logic            s2_last;
  logic [FW-1:0]   s2_idx;
  logic [MAGW-1:0] s2_mag;
  logic [MAGW-1:0] s2_thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_idx    <= '0;
      s2_mag    <= '0;
      s2_thresh <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first  <= (s1_beat == '0);
        s2_last   <= s1_last;
        // LANES is a power of two, so beat*LANES + lane is a shift plus an OR.
        s2_idx    <= (FW'(s1_beat) << LOG_LANES) | FW'(tree_idx);
        s2_mag    <= tree_mag;
        s2_thresh <= s1_thresh;
      end
    end
  end

  // S3: the first beat of a frame reloads the running max, so back-to-back
  // frames need no bubble between them.
  logic [FW-1:0]   acc_idx;
  logic [MAGW-1:0] acc_mag;
  logic [FW-1:0]   nxt_idx;
  logic [MAGW-1:0] nxt_mag;

  always_comb begin
    nxt_idx = acc_idx;
    nxt_mag = acc_mag;
    if (s2_first || (s2_mag > acc_mag)) begin
      nxt_idx = s2_idx;
      nxt_mag = s2_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idx   <= '0;
      acc_mag   <= '0;
      out_valid <= 1'b0;
      freq      <= '0;
      peak_mag  <= '0;
      hit       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        acc_idx <= nxt_idx;
        acc_mag <= nxt_mag;
        if (s2_last) begin
          freq     <= nxt_idx;
          peak_mag <= nxt_mag;
          hit      <= (nxt_mag >= s2_thresh);
        end
      end
    end
  end

endmodule
